// File: rtl/obuffer4_drain_pkg.sv
// obuffer4_drain_pkg: shared constants, FSM encoding and lane slicing helper for the output drain buffer.
package obuffer4_drain_pkg;
    localparam int NCOL  = 4;
    localparam int DST_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

    // Column 0 occupies the most significant lane of a row word.
    function automatic int lane_lsb(input int c, input int w);
        return (NCOL - 1 - c) * w;
    endfunction
endpackage

// File: rtl/obuffer4_drain_if.sv
// obuffer4_drain_if: row word valid/ready drain handshake towards writeback.
interface obuffer4_drain_if
    import obuffer4_drain_pkg::*;
#(
    parameter int ACC_W = 16
);
    logic [NCOL*ACC_W-1:0] OWord;
    logic                  OWord_VALID;
    logic                  OWord_READY;

    modport master (output OWord, output OWord_VALID, input OWord_READY);
    modport slave  (input OWord, input OWord_VALID, output OWord_READY);
endinterface

// File: rtl/obuf_col_fifo.sv
// obuf_col_fifo: one column result FIFO with push/pop, empty/full status and a sticky overflow flag.
module obuf_col_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_ovf
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_cnt;
    logic          r_ovf;
    logic          w_full, w_wr, w_rd;

    assign o_empty = r_cnt == '0;
    assign w_full  = r_cnt == (AW+1)'(DEPTH);
    assign w_rd    = i_pop & ~o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_wr    = i_push & (~w_full | w_rd);
    assign o_data  = r_mem[r_rd];
    assign o_ovf   = r_ovf;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_wr  <= r_wr + AW'(w_wr);
            r_rd  <= r_rd + AW'(w_rd);
            r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
            r_ovf <= r_ovf | (i_push & w_full & ~w_rd);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/obuffer4_drain.sv
// obuffer4_drain: de-skews 4 column result streams into row words and drains a tile over valid/ready.
// Optional OBUF_RELU_EN clamps negative elements to zero as rows load into OWord.
module obuffer4_drain
    import obuffer4_drain_pkg::*;
#(
    parameter int ACC_W  = 16,
    parameter int NROWS  = 4,
    parameter int FDEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic [NCOL-1:0]       OCOL_VALID,
    input  logic [NCOL*ACC_W-1:0] OROW_i,
    input  logic [DST_W-1:0]      ODST_i,
    obuffer4_drain_if.master      wb,
    output logic [DST_W-1:0]      ODST_o,
    output logic                  TILE_DONE,
    output logic                  OVF_ERR
);
    state_t                r_state, w_state_nxt;
    logic [3:0]            r_cnt;
    logic [DST_W-1:0]      r_dst;
    logic [NCOL*ACC_W-1:0] r_word, w_head, w_row;
    logic                  r_valid;
    logic [NCOL-1:0]       w_empty, w_ovf;
    logic                  w_load, w_acc;

    for (genvar c = 0; c < NCOL; c++) begin : g_col
        obuf_col_fifo #(.W(ACC_W), .DEPTH(FDEPTH)) u_fifo (
            .CLK     (CLK),
            .RSTN    (RSTN),
            .i_push  (OCOL_VALID[c]),
            .i_pop   (w_load),
            .i_data  (OROW_i[lane_lsb(c, ACC_W) +: ACC_W]),
            .o_data  (w_head[lane_lsb(c, ACC_W) +: ACC_W]),
            .o_empty (w_empty[c]),
            .o_ovf   (w_ovf[c])
        );
`ifdef OBUF_RELU_EN
        assign w_row[lane_lsb(c, ACC_W) +: ACC_W] =
            w_head[lane_lsb(c, ACC_W) + ACC_W - 1] ? '0 : w_head[lane_lsb(c, ACC_W) +: ACC_W];
`else
        assign w_row[lane_lsb(c, ACC_W) +: ACC_W] = w_head[lane_lsb(c, ACC_W) +: ACC_W];
`endif
    end

    assign w_acc          = r_valid & wb.OWord_READY;
    assign w_load         = ~|w_empty & (~r_valid | wb.OWord_READY);
    assign wb.OWord       = r_word;
    assign wb.OWord_VALID = r_valid;
    assign ODST_o         = r_dst;
    assign OVF_ERR        = |w_ovf;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dst   <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_load | (r_valid & ~wb.OWord_READY);
            if (w_load) r_word <= w_row;
            if (r_state == S_IDLE && |OCOL_VALID) begin
                r_dst <= ODST_i;
                r_cnt <= '0;
            end else if (r_state == S_COLLECT && w_acc) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        TILE_DONE   = 1'b0;
        if (r_state == S_IDLE)
            w_state_nxt = |OCOL_VALID ? S_COLLECT : S_IDLE;
        else if (r_state == S_COLLECT)
            w_state_nxt = (w_acc && r_cnt == 4'(NROWS - 1)) ? S_DONE : S_COLLECT;
        else begin
            w_state_nxt = S_IDLE;
            TILE_DONE   = 1'b1;
        end
    end
endmodule

// File: tb/tb_obuffer4_drain.sv
// tb_obuffer4_drain: scoreboard bench for the de-skew drain buffer (expected rows queued at drive time).
module tb_obuffer4_drain;
    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic [3:0]  OCOL_VALID = '0;
    logic [63:0] OROW_i = '0;
    logic [3:0]  ODST_i = '0;
    logic [3:0]  ODST_o;
    logic        TILE_DONE, OVF_ERR;
    int          errors = 0;
    int          checks = 0;
    logic [63:0] q [$];
    logic [63:0] r_hold;
    bit          hold = 1'b0;

    obuffer4_drain_if #(.ACC_W(16)) wb ();

    obuffer4_drain #(.ACC_W(16), .NROWS(4), .FDEPTH(4)) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .OCOL_VALID (OCOL_VALID),
        .OROW_i     (OROW_i),
        .ODST_i     (ODST_i),
        .wb         (wb.master),
        .ODST_o     (ODST_o),
        .TILE_DONE  (TILE_DONE),
        .OVF_ERR    (OVF_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] elem(input int tid, input int r, input int c);
        logic [63:0] sp = 64'hFFF0_0005_8000_7FFF;
        if (tid == 3 && r == 0) return sp[(3-c)*16 +: 16];
        return 16'(tid * 256 + 17 * (r + 1) + c);
    endfunction

    function automatic logic [63:0] row_exp(input int tid, input int r);
        logic [63:0] w;
        for (int c = 0; c < 4; c++) begin
            w[(3-c)*16 +: 16] = elem(tid, r, c);
`ifdef OBUF_RELU_EN
            if (w[(3-c)*16 + 15]) w[(3-c)*16 +: 16] = '0;
`endif
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic drive_tile(input logic [3:0] tag, input int tid, input int maxk);
        for (int r = 0; r < 4; r++) q.push_back(row_exp(tid, r));
        ODST_i = tag;
        for (int k = 0; k < 7 && k < maxk; k++) begin
            for (int c = 0; c < 4; c++) begin
                int r = k - c;
                OCOL_VALID[c] = (r >= 0 && r < 4);
                OROW_i[(3-c)*16 +: 16] = (r >= 0 && r < 4) ? elem(tid, r, c) : 16'h0;
            end
            tick();
        end
        OCOL_VALID = '0;
    endtask

    // Column 0 receives all its rows plus one extra before any other column starts.
    task automatic drive_ovf(input logic [3:0] tag, input int tid);
        for (int r = 0; r < 4; r++) q.push_back(row_exp(tid, r));
        ODST_i = tag;
        for (int k = 0; k < 5; k++) begin
            OCOL_VALID = 4'b0001;
            OROW_i = '0;
            OROW_i[63:48] = (k < 4) ? elem(tid, k, 0) : 16'hDEAD;
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            OCOL_VALID = '0;
            OROW_i = '0;
            for (int c = 1; c < 4; c++) begin
                int r = k - (c - 1);
                OCOL_VALID[c] = (r >= 0 && r < 4);
                OROW_i[(3-c)*16 +: 16] = (r >= 0 && r < 4) ? elem(tid, r, c) : 16'h0;
            end
            tick();
        end
        OCOL_VALID = '0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            tick();
            seen = TILE_DONE;
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    always @(negedge CLK) begin
        if (!RSTN) hold = 1'b0;
        else begin
            if (hold) begin
                chk("hold_valid", 64'(wb.OWord_VALID), 64'd1);
                chk("hold_word", wb.OWord, r_hold);
            end
            if (wb.OWord_VALID && wb.OWord_READY) begin
                chk("row_pending", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) chk("row", wb.OWord, q.pop_front());
            end
            hold   = wb.OWord_VALID && !wb.OWord_READY;
            r_hold = wb.OWord;
        end
    end

    initial begin
        wb.OWord_READY = 1'b1;
        #23;
        chk("rst_word", wb.OWord, 64'd0);
        chk("rst_valid", 64'(wb.OWord_VALID), 64'd0);
        chk("rst_dst", 64'(ODST_o), 64'd0);
        chk("rst_done", 64'(TILE_DONE), 64'd0);
        chk("rst_ovf", 64'(OVF_ERR), 64'd0);
        RSTN = 1'b1;
        tick();

        drive_tile(4'hA, 1, 99);
        wait_done("t1_done");
        chk("t1_dst", 64'(ODST_o), 64'hA);
        tick();
        chk("t1_pulse", 64'(TILE_DONE), 64'd0);
        chk("t1_drained", 64'(q.size()), 64'd0);

        wb.OWord_READY = 1'b0;
        drive_tile(4'h5, 2, 99);
        repeat (3) tick();
        wb.OWord_READY = 1'b1;
        wait_done("bp_done");
        chk("bp_ovf", 64'(OVF_ERR), 64'd0);
        chk("bp_dst", 64'(ODST_o), 64'h5);

        drive_tile(4'h6, 3, 99);
        wait_done("relu_done");

        drive_tile(4'h9, 4, 99);
        wait_done("b2b_done1");
        chk("b2b_dst1", 64'(ODST_o), 64'h9);
        drive_tile(4'h3, 5, 99);
        chk("b2b_dst2", 64'(ODST_o), 64'h3);
        wait_done("b2b_done2");
        chk("b2b_drained", 64'(q.size()), 64'd0);

        wb.OWord_READY = 1'b0;
        drive_ovf(4'hC, 6);
        chk("ovf_set", 64'(OVF_ERR), 64'd1);
        repeat (2) tick();
        wb.OWord_READY = 1'b1;
        wait_done("ovf_done");
        chk("ovf_sticky", 64'(OVF_ERR), 64'd1);
        chk("ovf_drained", 64'(q.size()), 64'd0);

        drive_tile(4'hD, 7, 6);
        RSTN = 1'b0;
        #1;
        chk("mid_word", wb.OWord, 64'd0);
        chk("mid_valid", 64'(wb.OWord_VALID), 64'd0);
        chk("mid_dst", 64'(ODST_o), 64'd0);
        chk("mid_done", 64'(TILE_DONE), 64'd0);
        chk("mid_ovf", 64'(OVF_ERR), 64'd0);
        q.delete();
        repeat (2) tick();
        RSTN = 1'b1;
        tick();
        drive_tile(4'hE, 2, 99);
        wait_done("post_done");
        chk("post_dst", 64'(ODST_o), 64'hE);
        repeat (3) tick();
        chk("post_drained", 64'(q.size()), 64'd0);
        chk("post_idle", 64'(wb.OWord_VALID), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
